// File: rtl/sleep_wake_classifier.sv
// sleep_wake_classifier
//   Scores each epoch from a 7-epoch activity window (t-4..t+2) with a serial
//   multiply-accumulate, one tap per cycle, and emits a sleep/wake decision.
//   Optional feature macro: SLEEP_RESCORE_EN (wake persists until SLEEP_RUN
//   consecutive sleep scores have been seen).
module sleep_wake_classifier #(
  // Listed newest tap first so that WEIGHTS[0] is the oldest tap (t-4).
  parameter logic [6:0][7:0] WEIGHTS   = {8'd8, 8'd12, 8'd32, 8'd10, 8'd8, 8'd14, 8'd10},
  parameter logic [18:0]     THRESHOLD = 19'd1000,
  parameter int              SLEEP_RUN = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  i_count,
  input  logic        i_valid,
  output logic [18:0] o_score,
  output logic        o_wake,
  output logic        o_valid,
  output logic        o_overrun
);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  taps_q [7];
  logic [1:0]  fill_q;
  logic [1:0]  fill_inc;
  logic [2:0]  idx_q;
  logic [18:0] acc_q;
  logic [18:0] score_q;
  logic        wake_q, wake_d;
  logic        valid_q;
  logic        overrun_q;
  logic        accept;
  logic        raw_wake;
  logic [7:0]  tap_sel;
  logic [7:0]  w_sel;
  logic [15:0] prod;

  // A sample is only taken while idle; anything else is an overrun.
  assign accept   = i_valid && (state_q == IDLE);
  assign fill_inc = (fill_q == 2'd3) ? 2'd3 : fill_q + 2'd1;
  assign raw_wake = (acc_q >= THRESHOLD);

  // Select the current tap and its weight for the serial MAC.
  always_comb begin
    tap_sel = 8'd0;
    w_sel   = 8'd0;
    for (int i = 0; i < 7; i++) begin
      if (idx_q == i[2:0]) begin
        tap_sel = taps_q[i];
        w_sel   = WEIGHTS[i];
      end
    end
    prod = {8'd0, tap_sel} * {8'd0, w_sel};
  end

  // Next-state logic: start once the centre tap holds a real epoch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && (fill_inc == 2'd3)) state_d = MAC;
      MAC:  if (idx_q == 3'd6) state_d = OUT;
      OUT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

`ifdef SLEEP_RESCORE_EN
  localparam logic [2:0] SLEEP_RUN_W = 3'(SLEEP_RUN);
  logic [2:0] run_q, run_d;
  logic [2:0] run_inc;

  // Wake is sticky until a full run of sleep scores; any wake restarts the run.
  always_comb begin
    run_inc = (run_q == 3'd7) ? 3'd7 : run_q + 3'd1;
    run_d   = run_q;
    wake_d  = wake_q;
    if (raw_wake) begin
      run_d  = 3'd0;
      wake_d = 1'b1;
    end else begin
      run_d  = run_inc;
      wake_d = wake_q && (run_inc < SLEEP_RUN_W);
    end
  end

  // Run counter advances once per scored epoch.
  always_ff @(posedge clk) begin
    if (!reset_n)             run_q <= 3'd0;
    else if (state_q == OUT)  run_q <= run_d;
  end
`else
  // Decision is the raw threshold comparison.
  always_comb begin
    wake_d = raw_wake;
  end
`endif

  // Window, fill counter, MAC datapath, output registers and overrun flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 7; i++) taps_q[i] <= 8'd0;
      fill_q    <= 2'd0;
      idx_q     <= 3'd0;
      acc_q     <= 19'd0;
      score_q   <= 19'd0;
      wake_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (accept) begin
        for (int i = 0; i < 6; i++) taps_q[i] <= taps_q[i+1];
        taps_q[6] <= i_count;
        fill_q    <= fill_inc;
      end
      case (state_q)
        IDLE: begin
          if (state_d == MAC) begin
            acc_q <= 19'd0;
            idx_q <= 3'd0;
          end
        end
        MAC: begin
          acc_q <= acc_q + {3'd0, prod};
          idx_q <= idx_q + 3'd1;
        end
        OUT: begin
          score_q <= acc_q;
          wake_q  <= wake_d;
        end
        default: ;
      endcase
      valid_q <= (state_q == OUT);
      if (i_valid && (state_q != IDLE)) overrun_q <= 1'b1;
    end
  end

  assign o_score   = score_q;
  assign o_wake    = wake_q;
  assign o_valid   = valid_q;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_sleep_wake_classifier.sv
// Scoreboard bench for sleep_wake_classifier: a window-level reference model
// predicts each decision and its arrival cycle; a monitor checks DUT outputs.
module tb_sleep_wake_classifier;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  i_count = 8'd0;
  logic        i_valid = 1'b0;
  logic [18:0] o_score;
  logic        o_wake;
  logic        o_valid;
  logic        o_overrun;

  sleep_wake_classifier dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_count   (i_count),
    .i_valid   (i_valid),
    .o_score   (o_score),
    .o_wake    (o_wake),
    .o_valid   (o_valid),
    .o_overrun (o_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int score;
    int wake;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  int   hist[$];
  int   n_acc = 0;
  int   last_score_cyc = -100;
  int   m_overrun = 0;
  int   m_wake = 0;
  int   m_run = 0;
  int   hold_score = 0;
  int   hold_wake = 0;
  int   total = 0;
  int   bad = 0;
  int   W [7] = '{10, 14, 8, 10, 32, 12, 8};
  localparam int THR = 1000;
  localparam int RUN = 4;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model for one offered sample at drive cycle k.
  task automatic model_input(input int c, input int k);
    int   score;
    int   tap;
    exp_t e;
    if (k - last_score_cyc < 9) begin
      m_overrun = 1;
      $display("input %0d at cycle %0d dropped (busy)", c, k);
      return;
    end
    hist.push_back(c);
    if (hist.size() > 7) void'(hist.pop_front());
    n_acc++;
    if (n_acc < 3) return;
    score = 0;
    for (int j = 0; j < 7; j++) begin
      tap = (6 - j < hist.size()) ? hist[hist.size() - 1 - (6 - j)] : 0;
      score += W[j] * tap;
    end
`ifdef SLEEP_RESCORE_EN
    if (score >= THR) begin
      m_wake = 1;
      m_run  = 0;
    end else begin
      m_run = (m_run < 7) ? m_run + 1 : 7;
      if (m_run >= RUN) m_wake = 0;
    end
`else
    m_wake = (score >= THR) ? 1 : 0;
`endif
    e.score = score;
    e.wake  = m_wake;
    e.cyc   = k + 9;
    sbq.push_back(e);
    last_score_cyc = k;
  endtask

  task automatic send(input int c, input int gap);
    @(posedge clk);
    #1;
    i_valid = 1'b1;
    i_count = 8'(c);
    model_input(c, cyc);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    hist.delete();
    sbq.delete();
    n_acc = 0;
    last_score_cyc = -100;
    m_overrun = 0;
    m_wake = 0;
    m_run = 0;
    repeat (n) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Monitor: pop and compare on every o_valid; otherwise outputs must hold.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      hold_score = 0;
      hold_wake  = 0;
    end else if (o_valid) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got score %0d with no expected output", o_score);
      end else begin
        e = sbq.pop_front();
        $display("out cycle %0d: score=%0d wake=%0d (exp %0d/%0d @%0d)",
                 cyc, o_score, o_wake, e.score, e.wake, e.cyc);
        check("score", int'(o_score), e.score);
        check("wake", int'(o_wake), e.wake);
        check("latency", cyc, e.cyc);
        check("overrun_at_out", int'(o_overrun), m_overrun);
        hold_score = e.score;
        hold_wake  = e.wake;
      end
    end else begin
      check("hold_score", int'(o_score), hold_score);
      check("hold_wake", int'(o_wake), hold_wake);
    end
  end

  initial begin
    int waited;
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", int'(o_valid), 0);
    check("rst_wake", int'(o_wake), 0);
    check("rst_score", int'(o_score), 0);
    check("rst_overrun", int'(o_overrun), 0);
    #1;
    reset_n = 1'b1;

    // Constant count 10, then 11
    for (int i = 0; i < 8; i++) send(10, 99);
    for (int i = 0; i < 7; i++) send(11, 99);

    // Single spike over a zero background
    for (int i = 0; i < 7; i++) send(0, 12);
    send(100, 12);
    for (int i = 0; i < 6; i++) send(0, 12);

    // Overrun: second sample 3 cycles after an accepted one
    send(5, 1);
    send(9, 20);
    @(negedge clk);
    check("overrun_set", int'(o_overrun), 1);
    send(6, 12);
    check("overrun_sticky", int'(o_overrun), 1);

    // Reset in the middle of the MAC
    send(7, 0);
    repeat (3) @(posedge clk);
    do_reset(2);
    @(negedge clk);
    check("overrun_cleared", int'(o_overrun), 0);
    check("score_cleared", int'(o_score), 0);
    for (int i = 0; i < 3; i++) send(12, 12);

    // Wake persistence pattern
    for (int i = 0; i < 7; i++) send(20, 12);
    for (int i = 0; i < 6; i++) send(0, 12);
    send(20, 12);
    for (int i = 0; i < 5; i++) send(0, 12);

    // Randomized counts and gaps (short gaps exercise drops)
    for (int i = 0; i < 80; i++) send(int'($urandom_range(0, 25)), int'($urandom_range(0, 12)));

    // Drain
    waited = 0;
    while (sbq.size() != 0 && waited < 50) begin
      @(posedge clk);
      waited++;
    end
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d outputs still pending expected 0", sbq.size());
    end
    @(negedge clk);
    check("final_overrun", int'(o_overrun), m_overrun);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
